// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, sequencer
// states, opcode classes and the control-strobe bundle.
package cpu_defs;

    localparam int          OP_W    = 5;
    localparam logic [4:0]  ALU_ADD = 5'b00011;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3,
        ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    // Opcodes grouped by the shape of their execute sequence.
    typedef enum logic [3:0] {
        CLS_LD, CLS_LDI, CLS_ST, CLS_ALU, CLS_IMM, CLS_MULDIV, CLS_UNARY,
        CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } op_class_t;

    typedef struct packed {
        logic read;
        logic write;
        logic inc_pc;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic hi_in;
        logic lo_in;
        logic y_in;
        logic z_in;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic outport_in;
        logic con_in;
        logic hi_out;
        logic lo_out;
        logic zhigh_out;
        logic zlow_out;
        logic pc_out;
        logic mdr_out;
        logic inport_out;
        logic c_out;
    } ctrl_t;

    // Unassigned codes (10101, 111xx) fall into the nop class.
    function automatic op_class_t classify(input logic [OP_W-1:0] op);
        op_class_t c;
        c = CLS_NOP;
        if (op == OP_LD)                          c = CLS_LD;
        else if (op == OP_LDI)                    c = CLS_LDI;
        else if (op == OP_ST)                     c = CLS_ST;
        else if (op <= OP_ROL)                    c = CLS_ALU;
        else if (op == OP_ADDI || op == OP_ANDI ||
                 op == OP_ORI)                    c = CLS_IMM;
        else if (op == OP_MUL || op == OP_DIV)    c = CLS_MULDIV;
        else if (op == OP_NEG || op == OP_NOT)    c = CLS_UNARY;
        else if (op == OP_BR)                     c = CLS_BR;
        else if (op == OP_JR)                     c = CLS_JR;
        else if (op == OP_IN)                     c = CLS_IN;
        else if (op == OP_OUT)                    c = CLS_OUT;
        else if (op == OP_MFHI)                   c = CLS_MFHI;
        else if (op == OP_MFLO)                   c = CLS_MFLO;
        else if (op == OP_HALT)                   c = CLS_HALT;
        return c;
    endfunction

    // Final step of each instruction class; the sequencer leaves it for T0 or HALT.
    function automatic state_t last_step(input op_class_t c);
        state_t s;
        case (c)
            CLS_LD, CLS_ST:                    s = ST_T7;
            CLS_MULDIV, CLS_BR:                s = ST_T6;
            CLS_ALU, CLS_IMM, CLS_LDI:         s = ST_T5;
            CLS_UNARY:                         s = ST_T4;
            CLS_JR, CLS_IN, CLS_OUT,
            CLS_MFHI, CLS_MFLO:                s = ST_T3;
            default:                           s = ST_T2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decode of (state, op, con_ff) into the datapath strobe bundle.
module control_decode
    import cpu_defs::*;
(
    input  state_t            state,
    input  logic [OP_W-1:0]   op,
    input  logic              con_ff,
    output ctrl_t             ctl,
    output logic [OP_W-1:0]   alu_op,
    output logic              run
);

    op_class_t cls;
    assign cls = classify(op);

    // Strobe decode: every output defaults inactive, then the current step sets its strobes.
    always_comb begin
        ctl    = '0;
        alu_op = ALU_ADD;
        run    = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
            end
            ST_T1: begin
                ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU, CLS_IMM: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; alu_op = op;
                    end
                    CLS_BR: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1;
                    end
                    CLS_IN: begin
                        ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    CLS_OUT: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1;
                    end
                    CLS_MFHI: begin
                        ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    CLS_MFLO: begin
                        ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_ALU: begin
                        ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; alu_op = op;
                    end
                    CLS_IMM: begin
                        ctl.c_out = 1'b1; ctl.z_in = 1'b1; alu_op = op;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctl.c_out = 1'b1; ctl.z_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; alu_op = op;
                    end
                    CLS_UNARY: begin
                        ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_ALU, CLS_IMM, CLS_LDI: begin
                        ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctl.c_out = 1'b1; ctl.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CLS_LD: begin
                        ctl.read = 1'b1; ctl.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1;
                    end
                    CLS_BR: begin
                        // Branch taken only when the CON FF latched a true condition in T3.
                        if (con_ff) begin
                            ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CLS_LD: begin
                        ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    CLS_ST: begin
                        ctl.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Mini SRC multicycle sequencer: state register plus next-state logic;
// strobe generation lives in control_decode.
module control_unit
    import cpu_defs::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [OP_W-1:0]   op,
    input  logic              con_ff,
    input  logic              stop,
    output logic              run,
    output logic [OP_W-1:0]   alu_op,
    output logic              Read,
    output logic              Write,
    output logic              IncPC,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              HIin,
    output logic              LOin,
    output logic              Yin,
    output logic              Zin,
    output logic              PCin,
    output logic              IRin,
    output logic              MARin,
    output logic              MDRin,
    output logic              OutPortin,
    output logic              CONin,
    output logic              HIout,
    output logic              LOout,
    output logic              Zhighout,
    output logic              Zlowout,
    output logic              PCout,
    output logic              MDRout,
    output logic              InPortout,
    output logic              Cout
);

    state_t    state;
    state_t    state_n;
    op_class_t cls;
    ctrl_t     ctl;

    assign cls = classify(op);

    // State register; clear overrides everything, including HALT.
    always_ff @(posedge clock) begin
        if (clear) state <= ST_RESET;
        else       state <= state_n;
    end

    // Next state: step T0..T7 in order, leave an instruction at its last step.
    always_comb begin
        state_n = state;
        case (state)
            ST_RESET: state_n = ST_T0;
            ST_HALT:  state_n = ST_HALT;
            ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (state == last_step(cls)) begin
                    if (cls == CLS_HALT || stop) state_n = ST_HALT;
                    else                         state_n = ST_T0;
                end else begin
                    state_n = state_t'(state + 4'd1);
                end
            end
            default:  state_n = ST_RESET;
        endcase
    end

    control_decode u_decode (
        .state  (state),
        .op     (op),
        .con_ff (con_ff),
        .ctl    (ctl),
        .alu_op (alu_op),
        .run    (run)
    );

    assign Read      = ctl.read;
    assign Write     = ctl.write;
    assign IncPC     = ctl.inc_pc;
    assign Gra       = ctl.gra;
    assign Grb       = ctl.grb;
    assign Grc       = ctl.grc;
    assign Rin       = ctl.r_in;
    assign Rout      = ctl.r_out;
    assign BAout     = ctl.ba_out;
    assign HIin      = ctl.hi_in;
    assign LOin      = ctl.lo_in;
    assign Yin       = ctl.y_in;
    assign Zin       = ctl.z_in;
    assign PCin      = ctl.pc_in;
    assign IRin      = ctl.ir_in;
    assign MARin     = ctl.mar_in;
    assign MDRin     = ctl.mdr_in;
    assign OutPortin = ctl.outport_in;
    assign CONin     = ctl.con_in;
    assign HIout     = ctl.hi_out;
    assign LOout     = ctl.lo_out;
    assign Zhighout  = ctl.zhigh_out;
    assign Zlowout   = ctl.zlow_out;
    assign PCout     = ctl.pc_out;
    assign MDRout    = ctl.mdr_out;
    assign InPortout = ctl.inport_out;
    assign Cout      = ctl.c_out;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues the expected output
// word for every cycle, a monitor compares it on the falling edge.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       clear;
    logic [4:0] op;
    logic       con_ff;
    logic       stop;
    logic       run;
    logic [4:0] alu_op;
    logic Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
    logic HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, OutPortin, CONin;
    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;

    control_unit dut (
        .clock(clock), .clear(clear), .op(op), .con_ff(con_ff), .stop(stop),
        .run(run), .alu_op(alu_op), .Read(Read), .Write(Write), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
        .MARin(MARin), .MDRin(MDRin), .OutPortin(OutPortin), .CONin(CONin),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout)
    );

    always #5 clock = ~clock;

    localparam logic [26:0] COUT = 27'd1 << 0,  INPORTOUT = 27'd1 << 1,
                            MDROUT = 27'd1 << 2, PCOUT = 27'd1 << 3,
                            ZLOWOUT = 27'd1 << 4, ZHIGHOUT = 27'd1 << 5,
                            LOOUT = 27'd1 << 6, HIOUT = 27'd1 << 7,
                            CONIN = 27'd1 << 8, OUTPORTIN = 27'd1 << 9,
                            MDRIN = 27'd1 << 10, MARIN = 27'd1 << 11,
                            IRIN = 27'd1 << 12, PCIN = 27'd1 << 13,
                            ZIN = 27'd1 << 14, YIN = 27'd1 << 15,
                            LOIN = 27'd1 << 16, HIIN = 27'd1 << 17,
                            BAOUT = 27'd1 << 18, ROUT = 27'd1 << 19,
                            RIN = 27'd1 << 20, GRC = 27'd1 << 21,
                            GRB = 27'd1 << 22, GRA = 27'd1 << 23,
                            INCPC = 27'd1 << 24, WRITE = 27'd1 << 25,
                            READ = 27'd1 << 26;

    localparam logic [4:0] ADD = 5'b00011;

    logic [32:0] act;
    assign act = {run, alu_op, Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
                  HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, OutPortin, CONin,
                  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout};

    logic [32:0] exp_q[$];
    string       name_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Monitor: one expected word per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                logic [32:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL %s: got run=%b alu=%b strobes=%h, want run=%b alu=%b strobes=%h",
                             n, act[32], act[31:27], act[26:0], e[32], e[31:27], e[26:0]);
                end
            end
        end
    end

    // One cycle: after the edge, set inputs and queue the outputs of the state just entered.
    task automatic step(input logic [4:0] o, input logic c, input logic s, input logic clr,
                        input logic r, input logic [4:0] a, input logic [26:0] st,
                        input string n);
        @(posedge clock);
        #1;
        op = o; con_ff = c; stop = s; clear = clr;
        exp_q.push_back({r, a, st});
        name_q.push_back(n);
    endtask

    task automatic fetch(input logic [4:0] o, input string n);
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, ADD, PCOUT | MARIN | INCPC | ZIN, {n, "_t0"});
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZLOWOUT | PCIN | READ | MDRIN, {n, "_t1"});
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, ADD, MDROUT | IRIN, {n, "_t2"});
    endtask

    task automatic rtype(input logic [4:0] o, input string n);
        fetch(o, n);
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, ADD, GRB | ROUT | YIN, {n, "_t3"});
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, o,   GRC | ROUT | ZIN, {n, "_t4"});
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZLOWOUT | GRA | RIN, {n, "_t5"});
    endtask

    task automatic mem_addr(input logic [4:0] o, input string n);
        fetch(o, n);
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, ADD, GRB | BAOUT | YIN, {n, "_t3"});
        step(o, 1'b0, 1'b0, 1'b0, 1'b1, ADD, COUT | ZIN, {n, "_t4"});
    endtask

    task automatic branch(input logic c, input logic [26:0] t6, input string n);
        fetch(5'b10011, n);
        step(5'b10011, c, 1'b0, 1'b0, 1'b1, ADD, GRA | ROUT | CONIN, {n, "_t3"});
        step(5'b10011, c, 1'b0, 1'b0, 1'b1, ADD, PCOUT | YIN, {n, "_t4"});
        step(5'b10011, c, 1'b0, 1'b0, 1'b1, ADD, COUT | ZIN, {n, "_t5"});
        step(5'b10011, c, 1'b0, 1'b0, 1'b1, ADD, t6, {n, "_t6"});
    endtask

    initial begin
        clear = 1'b1; op = 5'b11010; con_ff = 1'b0; stop = 1'b0;

        step(5'b11010, 1'b0, 1'b0, 1'b0, 1'b0, ADD, 27'd0, "reset");
        fetch(5'b11010, "nop");
        fetch(5'b11101, "unused_op");

        rtype(5'b00011, "add");
        rtype(5'b00100, "sub");

        fetch(5'b01101, "andi");
        step(5'b01101, 1'b0, 1'b0, 1'b0, 1'b1, ADD, GRB | ROUT | YIN, "andi_t3");
        step(5'b01101, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01101, COUT | ZIN, "andi_t4");
        step(5'b01101, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZLOWOUT | GRA | RIN, "andi_t5");

        mem_addr(5'b00000, "ld");
        step(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZLOWOUT | MARIN, "ld_t5");
        step(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, ADD, READ | MDRIN, "ld_t6");
        step(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, ADD, MDROUT | GRA | RIN, "ld_t7");

        mem_addr(5'b00010, "st");
        step(5'b00010, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZLOWOUT | MARIN, "st_t5");
        step(5'b00010, 1'b0, 1'b0, 1'b0, 1'b1, ADD, GRA | ROUT | MDRIN, "st_t6");
        step(5'b00010, 1'b0, 1'b0, 1'b0, 1'b1, ADD, WRITE, "st_t7");

        branch(1'b1, ZLOWOUT | PCIN, "br_taken");
        branch(1'b0, 27'd0, "br_not_taken");

        fetch(5'b01111, "mul");
        step(5'b01111, 1'b0, 1'b0, 1'b0, 1'b1, ADD, GRA | ROUT | YIN, "mul_t3");
        step(5'b01111, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01111, GRB | ROUT | ZIN, "mul_t4");
        step(5'b01111, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZLOWOUT | LOIN, "mul_t5");
        step(5'b01111, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZHIGHOUT | HIIN, "mul_t6");

        fetch(5'b10001, "neg");
        step(5'b10001, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10001, GRB | ROUT | ZIN, "neg_t3");
        step(5'b10001, 1'b0, 1'b0, 1'b0, 1'b1, ADD, ZLOWOUT | GRA | RIN, "neg_t4");

        fetch(5'b11000, "mfhi");
        step(5'b11000, 1'b0, 1'b0, 1'b0, 1'b1, ADD, HIOUT | GRA | RIN, "mfhi_t3");
        fetch(5'b10100, "jr");
        step(5'b10100, 1'b0, 1'b0, 1'b0, 1'b1, ADD, GRA | ROUT | PCIN, "jr_t3");

        // stop raised in add T4: add finishes T5 then halts
        fetch(5'b00011, "stop_add");
        step(5'b00011, 1'b0, 1'b0, 1'b0, 1'b1, ADD, GRB | ROUT | YIN, "stop_add_t3");
        step(5'b00011, 1'b0, 1'b1, 1'b0, 1'b1, ADD, GRC | ROUT | ZIN, "stop_add_t4");
        step(5'b00011, 1'b0, 1'b1, 1'b0, 1'b1, ADD, ZLOWOUT | GRA | RIN, "stop_add_t5");
        for (int i = 0; i < 3; i++)
            step(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, ADD, 27'd0, "stop_halt");
        step(5'b00011, 1'b0, 1'b0, 1'b1, 1'b0, ADD, 27'd0, "stop_halt_clr");
        step(5'b11010, 1'b0, 1'b0, 1'b0, 1'b0, ADD, 27'd0, "stop_reset");
        fetch(5'b11010, "after_stop");

        // halt instruction: held for 10 cycles, then cleared
        fetch(5'b11011, "halt");
        for (int i = 0; i < 10; i++)
            step(5'b11011, 1'b0, 1'b0, 1'b0, 1'b0, ADD, 27'd0, "halt_hold");
        step(5'b11011, 1'b0, 1'b0, 1'b1, 1'b0, ADD, 27'd0, "halt_clr");
        step(5'b11010, 1'b0, 1'b0, 1'b0, 1'b0, ADD, 27'd0, "halt_reset");
        fetch(5'b11010, "after_halt");

        // clear at ld T5 aborts the instruction
        mem_addr(5'b00000, "ld_abort");
        step(5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, ADD, ZLOWOUT | MARIN, "ld_abort_t5");
        step(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, ADD, 27'd0, "ld_abort_reset");
        fetch(5'b11010, "after_abort");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multicycle sequencer for the Mini SRC CPU. It sits directly upstream of the datapath and drives every datapath control strobe. Each instruction is stepped through fetch (T0–T2) and then an opcode-specific execute sequence (T3–T7). It reads the IR opcode and the CON flip-flop output back from the datapath, and halts on the halt instruction or an external stop request.

Parameters:
OP_W, 5, opcode width (IR[31:27])
ALU_ADD, 5'b00011, ALU code driven for address and branch-target arithmetic

Ports:
clock  input  1  system clock, rising edge
clear  input  1  synchronous active-high reset
op  input  5  IR[31:27] from datapath
con_ff  input  1  branch condition from datapath CON FF
stop  input  1  external halt request, level-sensitive
run  output  1  1 while executing; 0 in RESET and HALT
alu_op  output  5  opcode to ALU
Read, Write  output  1 each  memory strobes
IncPC  output  1  ALU computes bus+1
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select/encode controls
HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, OutPortin, CONin  output  1 each  register load enables
HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout  output  1 each  bus drive selects

Behaviour:
- Registered state: RESET, T0..T7, HALT. All outputs are a combinational decode of (state, op, con_ff).
- clear=1 at an edge → state RESET, regardless of current state, including mid-instruction or HALT.
- In RESET: all strobes 0, run=0, alu_op=ALU_ADD. RESET → T0 on the next edge with clear=0.
- Any state not listed for a step drives all strobes 0. alu_op defaults to ALU_ADD.
- Opcodes: ld 00000, ldi 00001, st 00010, add..rol 00011–01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011. Codes 10101 and 11100–11111 execute as nop.
- Fetch (all opcodes):
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, Read, MDRin
  - T2: MDRout, IRin
- R-type ALU (00011–01011): T3 Grb Rout Yin; T4 Grc Rout Zin, alu_op=op; T5 Zlowout Gra Rin.
- addi/andi/ori: T3 Grb Rout Yin; T4 Cout Zin, alu_op=op; T5 Zlowout Gra Rin.
- ldi: T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout Gra Rin.
- ld: T3 Grb BAout Yin; T4 Cout Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin with Read=0; T7 Write.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout Zin, alu_op=op; T5 Zlowout LOin; T6 Zhighout HIin.
- neg/not: T3 Grb Rout Zin, alu_op=op; T4 Zlowout Gra Rin.
- br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 Zlowout PCin only if con_ff=1, otherwise idle.
- jr: T3 Gra Rout PCin.
- in: T3 InPortout Gra Rin. out: T3 Gra Rout OutPortin.
- mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
- nop: T2 → T0 directly.
- halt: T2 → HALT.
- Last step of each sequence → T0, unless stop=1 at that edge, in which case → HALT.
- HALT: all strobes 0, run=0. HALT is exited only by clear.
- Latency: nop 3 cycles; R-type 6; ld/st 8; br 7; mul/div 7.
- Exactly one bus driver is active per step. Outputs are glitch-free relative to the state register.

Decomposition:
- Shared package cpu_defs: opcode localparams, state encodings, ALU_ADD.
- One natural sub-module: control_decode, a purely combinational (state, op, con_ff) → strobe vector. control_unit keeps only the state register and next-state logic.

Test Plan:
- Fetch: clear 1 cycle, then op=11010 (nop) → T0 shows PCout/MARin/IncPC/Zin, T1 Read/MDRin/PCin, T2 IRin; T0 again at cycle 4.
- add (op=00011) → T4 alu_op=00011 with Grc/Rout/Zin; T5 Zlowout/Gra/Rin; back to T0, 6 cycles total.
- ld (op=00000) → T6 Read=1 with MDRin; T7 MDRout/Gra/Rin; st (op=00010) → T6 Read=0 with MDRin, T7 Write=1.
- br with con_ff=1 → PCin in T6; con_ff=0 → no PCin in T6; both return to T0.
- halt (op=11011) → HALT after T2, run=0 and held for 10 cycles; clear → RESET → T0.
- stop=1 during add T4 → instruction completes through T5, then HALT. clear asserted at ld T5 → RESET next cycle, Write never asserted.
